inst_fetch_ctrl: RTL

Instruction-fetch bus sequencer between the PC register stage and the instruction memory bus.
- Turns each PC value (cpu_addr, qualified by cpu_ce) into a single-beat bus read and returns the instruction word to IF/ID.
- Holds the PC via stallreq until data arrives.
- Handles pipeline stalls and flushes, including a flush that arrives while a bus read is outstanding.

---
 rtl/inst_fetch_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
// Instruction-fetch bus sequencer between the PC stage and the instruction
// memory bus. Each PC (cpu_addr qualified by cpu_ce) becomes one single-beat
// bus read. The PC is held through stallreq until the word arrives. The word
// is returned to IF/ID. Pipeline stalls hold the word in a buffer. A flush
// that hits an outstanding read drains that read and discards its data.
//
// Optional feature: define FETCH_TIMEOUT_EN to build a watchdog. The watchdog
// abandons a read that gets no bus_ack within TIMEOUT_CYC cycles.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active-low
//   stall_ctrl     pipeline stall vector, bit1 = IF/ID stalled
//   flush          pipeline flush (exception redirect)
//   cpu_ce         fetch enable from the PC stage
//   cpu_addr       current PC
//   cpu_rdata      instruction to IF/ID (combinational)
//   stallreq       fetch stall request (combinational)
//   bus_req        bus cycle strobe (registered)
//   bus_addr       bus read address (registered, stable per transaction)
//   bus_ack        bus acknowledge, bus_rdata valid in the same cycle
//   bus_rdata      bus read data
//   fetch_timeout  one-cycle pulse on watchdog expiry (0 without the feature)
module inst_fetch_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] NOP_INST    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_ctrl,
  input  logic              flush,
  input  logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stallreq,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              fetch_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] inst_buf;
  logic [DATA_W-1:0] rdata_c;
  logic              stallreq_c;
  logic              timeout_c;
  logic              load_addr;
  logic              take_buf;
  logic              ack;
  logic              expire;

  // Only the IF/ID bit of the stall vector matters to the fetch stage.
  logic unused_stall;
  assign unused_stall = ^{stall_ctrl[5:2], stall_ctrl[0]};

  // An ack outside a bus cycle is not ours.
  assign ack = bus_ack & bus_req;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [WD_W-1:0] wdog;
  logic            in_bus;
  logic            stay_bus;

  assign in_bus   = (state == BUSY) || (state == DRAIN);
  assign stay_bus = (state_next == BUSY) || (state_next == DRAIN);
  // The counter holds 0 in the first bus cycle. Expiry therefore falls in
  // cycle number TIMEOUT_CYC.
  assign expire   = in_bus && !ack && (wdog == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
    end else if (in_bus && stay_bus) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    stallreq_c = 1'b0;
    rdata_c    = NOP_INST;
    timeout_c  = 1'b0;
    load_addr  = 1'b0;
    take_buf   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_ce && !flush) begin
          state_next = BUSY;
          stallreq_c = 1'b1;
          load_addr  = 1'b1;
        end
      end
      BUSY: begin
        if (expire) begin
          // Abandon the read and let the pipeline advance with a NOP.
          state_next = IDLE;
          timeout_c  = 1'b1;
        end else if (flush) begin
          if (ack) begin
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
            stallreq_c = 1'b1;
          end
        end else if (ack) begin
          rdata_c    = bus_rdata;
          take_buf   = 1'b1;
          state_next = stall_ctrl[1] ? HOLD : IDLE;
        end else begin
          stallreq_c = 1'b1;
        end
      end
      HOLD: begin
        rdata_c = inst_buf;
        if (flush || !stall_ctrl[1]) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        stallreq_c = 1'b1;
        if (expire) begin
          state_next = IDLE;
          timeout_c  = 1'b1;
        end else if (ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset already forces IDLE. IDLE can still raise stallreq from cpu_ce,
  // so the output is gated by rst as well.
  assign stallreq      = stallreq_c & rst;
  assign cpu_rdata     = rdata_c;
  assign fetch_timeout = timeout_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      inst_buf <= '0;
    end else begin
      state   <= state_next;
      // The strobe stays up exactly while a read is outstanding.
      bus_req <= (state_next == BUSY) || (state_next == DRAIN);
      if (load_addr) begin
        bus_addr <= cpu_addr;
      end
      if (take_buf) begin
        inst_buf <= bus_rdata;
      end
    end
  end

endmodule
